waveform_analyzer: RTL and testbench



---
 rtl/waveform_analyzer_pkg.sv | 10 +
 rtl/waveform_analyzer_sync_edge_detect.sv | 27 ++
 rtl/waveform_analyzer.sv | 80 ++++++++
 tb/tb_waveform_analyzer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/waveform_analyzer_pkg.sv
// waveform_analyzer_pkg: shared state encoding and default sizes for the waveform analyzer
package waveform_analyzer_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int MIN_SYNC_STAGES = 2;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;
endpackage

// File: rtl/waveform_analyzer_sync_edge_detect.sv
// waveform_analyzer_sync_edge_detect: synchronizer with preset-to-1 chain and rise/fall detection
module waveform_analyzer_sync_edge_detect
  import waveform_analyzer_pkg::*;
#(
  parameter int STAGES = MIN_SYNC_STAGES
) (
  input  logic clock,
  input  logic clear,
  input  logic sig,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic s_prev;
  // chain and s_prev preset high so a high input held through clear is not seen as a rise
  always_ff @(posedge clock) begin
    if (clear) begin
      chain <= '1;
      s_prev <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], sig};
      s_prev <= chain[STAGES-1];
    end
  end
  assign rise = chain[STAGES-1] & ~s_prev;
  assign fall = ~chain[STAGES-1] & s_prev;
endmodule

// File: rtl/waveform_analyzer.sv
// waveform_analyzer: measures high time and period of each cycle of an asynchronous waveform
module waveform_analyzer
  import waveform_analyzer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SYNC_STAGES = MIN_SYNC_STAGES
) (
  input  logic clock,
  input  logic clear,
  input  logic wave_in,
  output logic [WIDTH-1:0] high_count,
  output logic [WIDTH-1:0] period_count,
  output logic valid,
  output logic overflow,
  output logic busy
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic rise, fall, ovf, h_sat, p_sat;
  logic [WIDTH-1:0] hcnt, pcnt, hcnt_inc, pcnt_inc;
  state_t state;
  waveform_analyzer_sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clock(clock),
    .clear(clear),
    .sig(wave_in),
    .rise(rise),
    .fall(fall)
  );
  assign h_sat = &hcnt;
  assign p_sat = &pcnt;
  assign hcnt_inc = h_sat ? hcnt : hcnt + ONE;
  assign pcnt_inc = p_sat ? pcnt : pcnt + ONE;
  // measurement FSM: a rise closes the previous period and immediately opens the next
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      hcnt <= '0;
      pcnt <= '0;
      ovf <= 1'b0;
      high_count <= '0;
      period_count <= '0;
      valid <= 1'b0;
      overflow <= 1'b0;
      busy <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (rise) begin
          hcnt <= ONE;
          pcnt <= ONE;
          ovf <= 1'b0;
          state <= HIGH;
          busy <= 1'b1;
        end
        HIGH: begin
          pcnt <= pcnt_inc;
          hcnt <= fall ? hcnt : hcnt_inc;
          ovf <= ovf | p_sat | (~fall & h_sat);
          if (fall) state <= LOW;
        end
        LOW: if (rise) begin
          high_count <= hcnt;
          period_count <= pcnt;
          overflow <= ovf;
          valid <= 1'b1;
          hcnt <= ONE;
          pcnt <= ONE;
          ovf <= 1'b0;
          state <= HIGH;
        end else begin
          pcnt <= pcnt_inc;
          ovf <= ovf | p_sat;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_waveform_analyzer.sv
// tb_waveform_analyzer: directed and randomized checks of two sync depths against a behavioural model
module tb_waveform_analyzer;
  localparam int MAXC = 16384;
  localparam int MAXR = 1024;
  logic clock = 1'b0;
  logic clear = 1'b1;
  logic wave_in = 1'b1;
  logic [3:0] hc [2];
  logic [3:0] pc [2];
  logic vld [2];
  logic ovf [2];
  logic bsy [2];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit exp_v [2][MAXC];
  int exp_h [2][MAXC];
  int exp_p [2][MAXC];
  bit exp_o [2][MAXC];
  bit pv [2];
  bit have [2];
  int rise_e [2];
  int fall_e [2];
  int busy_due [2];
  int lh [2];
  int lp [2];
  bit lo [2];
  int nrep [2];
  int base [2];
  int rh [2][MAXR];
  int rp [2][MAXR];
  int ro [2][MAXR];
  int vlast [2];
  int kr;

  always #5 clock = ~clock;

  waveform_analyzer #(.WIDTH(4), .SYNC_STAGES(2)) dut2 (
    .clock(clock), .clear(clear), .wave_in(wave_in),
    .high_count(hc[0]), .period_count(pc[0]), .valid(vld[0]), .overflow(ovf[0]), .busy(bsy[0])
  );
  waveform_analyzer #(.WIDTH(4), .SYNC_STAGES(3)) dut3 (
    .clock(clock), .clear(clear), .wave_in(wave_in),
    .high_count(hc[1]), .period_count(pc[1]), .valid(vld[1]), .overflow(ovf[1]), .busy(bsy[1])
  );

  function automatic int sat(input int v);
    return v > 15 ? 15 : v;
  endfunction

  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s sync=%0d cycle %0d: got %0d expected %0d", nm, i + 2, cyc, act, exp);
    end
  endtask

  // Model on raw samples: a rise sampled at edge r closes the period begun at the previous
  // rise and must be reported N edges later; a clear forgets everything in flight.
  task automatic model_step(input int i, input int e);
    int n = i + 2;
    if (clear) begin
      pv[i] = 1'b1;
      have[i] = 1'b0;
      busy_due[i] = -1;
      lh[i] = 0;
      lp[i] = 0;
      lo[i] = 1'b0;
      for (int j = 0; j < 5; j++) exp_v[i][e + j] = 1'b0;
    end else begin
      if (wave_in && !pv[i]) begin
        if (have[i]) begin
          exp_v[i][e + n] = 1'b1;
          exp_h[i][e + n] = sat(fall_e[i] - rise_e[i]);
          exp_p[i][e + n] = sat(e - rise_e[i]);
          exp_o[i][e + n] = (e - rise_e[i]) > 15;
        end else begin
          have[i] = 1'b1;
          busy_due[i] = e + n;
        end
        rise_e[i] = e;
      end else if (!wave_in && pv[i] && have[i]) fall_e[i] = e;
      pv[i] = wave_in;
      if (exp_v[i][e]) begin
        lh[i] = exp_h[i][e];
        lp[i] = exp_p[i][e];
        lo[i] = exp_o[i][e];
      end
    end
  endtask

  // single compare process: model advances at the edge, DUT is sampled 1 unit later
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      if (cyc >= MAXC - 8) begin
        $display("FAIL cycle_budget: got %0d cycles expected fewer than %0d", cyc, MAXC - 8);
        $fatal(1);
      end
      for (int i = 0; i < 2; i++) model_step(i, cyc);
      #1;
      for (int i = 0; i < 2; i++) begin
        chk("valid", i, int'(vld[i]), int'(exp_v[i][cyc]));
        chk("busy", i, int'(bsy[i]), int'(busy_due[i] >= 0 && cyc >= busy_due[i]));
        chk("high_count", i, int'(hc[i]), lh[i]);
        chk("period_count", i, int'(pc[i]), lp[i]);
        chk("overflow", i, int'(ovf[i]), int'(lo[i]));
        if (vld[i] === 1'b1 && nrep[i] < MAXR) begin
          rh[i][nrep[i]] = int'(hc[i]);
          rp[i][nrep[i]] = int'(pc[i]);
          ro[i][nrep[i]] = int'(ovf[i]);
          vlast[i] = cyc;
          nrep[i]++;
        end
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic seg(input int hi, input int lw);
    wave_in = 1'b1;
    tick(hi);
    wave_in = 1'b0;
    tick(lw);
  endtask

  task automatic do_clear(input bit w);
    clear = 1'b1;
    wave_in = w;
    tick(2);
    clear = 1'b0;
  endtask

  task automatic mark();
    for (int i = 0; i < 2; i++) base[i] = nrep[i];
  endtask

  task automatic exp_count(input string nm, input int n);
    for (int i = 0; i < 2; i++) chk(nm, i, nrep[i] - base[i], n);
  endtask

  task automatic exp_rep(input int k, input int h, input int p, input int o);
    for (int i = 0; i < 2; i++) begin
      chk("rep_high", i, rh[i][base[i] + k], h);
      chk("rep_period", i, rp[i][base[i] + k], p);
      chk("rep_overflow", i, ro[i][base[i] + k], o);
    end
  endtask

  initial begin
    @(negedge clock);
    do_clear(1'b1);
    mark();
    tick(50);
    for (int i = 0; i < 2; i++) chk("idle_busy_const_high", i, int'(bsy[i]), 0);
    exp_count("count_const_high", 0);
    wave_in = 1'b0;
    tick(3);
    wave_in = 1'b1;
    tick(5);
    for (int i = 0; i < 2; i++) chk("busy_after_first_rise", i, int'(bsy[i]), 1);
    exp_count("count_first_rise", 0);
    wave_in = 1'b0;
    tick(3);
    wave_in = 1'b1;
    tick(5);
    exp_count("count_second_rise", 1);
    exp_rep(0, 5, 8, 0);
    mark();
    do_clear(1'b1);
    tick(1);
    for (int i = 0; i < 2; i++) chk("busy_after_mid_clear", i, int'(bsy[i]), 0);
    wave_in = 1'b0;
    tick(2);
    seg(4, 4);
    seg(4, 4);
    wave_in = 1'b1;
    tick(6);
    exp_count("count_restart", 2);
    exp_rep(0, 4, 8, 0);
    exp_rep(1, 4, 8, 0);
    do_clear(1'b0);
    mark();
    tick(50);
    for (int i = 0; i < 2; i++) chk("idle_busy_const_low", i, int'(bsy[i]), 0);
    exp_count("count_const_low", 0);
    do_clear(1'b0);
    tick(2);
    mark();
    for (int k = 0; k < 6; k++) seg(3, 5);
    wave_in = 1'b1;
    tick(6);
    exp_count("count_basic", 6);
    for (int k = 0; k < 6; k++) exp_rep(k, 3, 8, 0);
    do_clear(1'b0);
    tick(2);
    mark();
    seg(1, 1);
    seg(7, 1);
    seg(1, 14);
    wave_in = 1'b1;
    tick(6);
    exp_count("count_duty", 3);
    exp_rep(0, 1, 2, 0);
    exp_rep(1, 7, 8, 0);
    exp_rep(2, 1, 15, 0);
    do_clear(1'b0);
    tick(2);
    mark();
    seg(10, 10);
    seg(2, 2);
    wave_in = 1'b1;
    tick(6);
    exp_count("count_saturation", 2);
    exp_rep(0, 10, 15, 1);
    exp_rep(1, 2, 4, 0);
    do_clear(1'b0);
    tick(2);
    seg(2, 2);
    kr = cyc + 1;
    wave_in = 1'b1;
    tick(6);
    for (int i = 0; i < 2; i++) chk("latency", i, vlast[i] - kr, i + 2);
    do_clear(1'b0);
    tick(2);
    for (int k = 0; k < 300; k++) begin
      seg(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)));
      if ($urandom_range(0, 39) == 0) begin
        do_clear(1'($urandom_range(0, 1)));
        tick(int'($urandom_range(0, 3)));
      end
    end
    tick(8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
